// File: rtl/recepcao_serial_matriz.sv
// Receive controller: stores serial bytes into a LINHAS x COLUNAS matrix in raster order.
// Write issues 1 cycle after an accepted byte; no backpressure, bytes outside espera_dado are dropped.
module recepcao_serial_matriz #(
    parameter int LINHAS  = 3,
    parameter int COLUNAS = 3,
    parameter int DADO_W  = 8,
    parameter int TIMEOUT = 50000000,
    localparam int LW = (LINHAS  > 1) ? $clog2(LINHAS)  : 1,
    localparam int CW = (COLUNAS > 1) ? $clog2(COLUNAS) : 1,
    localparam int TW = $clog2(TIMEOUT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              pronto_rx,
    input  logic [DADO_W-1:0] dado_rx,
    input  logic              erro_rx,
    output logic              escreve,
    output logic [LW-1:0]     endereco_linha,
    output logic [CW-1:0]     endereco_coluna,
    output logic [DADO_W-1:0] dado_escrita,
    output logic              pronto,
    output logic              erro,
    output logic [3:0]        db_estado
);

    typedef enum logic [3:0] {
        INICIAL      = 4'b0000,
        PREPARACAO   = 4'b0001,
        ESPERA_DADO  = 4'b0010,
        ARMAZENA     = 4'b0011,
        CONTA_COLUNA = 4'b0101,
        CONTA_LINHA  = 4'b0110,
        FINAL        = 4'b0111,
        ERRO         = 4'b1000
    } estado_t;

    localparam logic [LW-1:0] LIN_MAX = LW'(LINHAS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLUNAS - 1);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT - 1);

    estado_t           estado_q, estado_d;
    logic [LW-1:0]     linha_q;
    logic [CW-1:0]     coluna_q;
    logic [TW-1:0]     timer_q;
    logic [DADO_W-1:0] dado_q;

    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:      estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:   estado_d = ESPERA_DADO;
            ESPERA_DADO: begin
                // An arriving byte wins over a timeout expiring on the same cycle.
                if (pronto_rx && erro_rx)  estado_d = ERRO;
                else if (pronto_rx)        estado_d = ARMAZENA;
                else if (timer_q == T_MAX) estado_d = ERRO;
                else                       estado_d = ESPERA_DADO;
            end
            ARMAZENA:     estado_d = CONTA_COLUNA;
            CONTA_COLUNA: estado_d = (coluna_q == COL_MAX) ? CONTA_LINHA : ESPERA_DADO;
            CONTA_LINHA:  estado_d = (linha_q == LIN_MAX) ? FINAL : ESPERA_DADO;
            FINAL:        estado_d = INICIAL;
            ERRO:         estado_d = iniciar ? PREPARACAO : ERRO;
            default:      estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            linha_q  <= '0;
            coluna_q <= '0;
            timer_q  <= '0;
            dado_q   <= '0;
        end else begin
            estado_q <= estado_d;
            case (estado_q)
                PREPARACAO: begin
                    linha_q  <= '0;
                    coluna_q <= '0;
                end
                ESPERA_DADO: begin
                    timer_q <= timer_q + TW'(1);
                    if (pronto_rx && !erro_rx) dado_q <= dado_rx;
                end
                CONTA_COLUNA: coluna_q <= (coluna_q == COL_MAX) ? '0 : coluna_q + CW'(1);
                CONTA_LINHA: begin
                    // Last line is held so the address reads (LINHAS-1, 0) after completion.
                    if (linha_q != LIN_MAX) linha_q <= linha_q + LW'(1);
                end
                default: ;
            endcase
            if (estado_d == ESPERA_DADO && estado_q != ESPERA_DADO) timer_q <= '0;
        end
    end

    assign escreve         = (estado_q == ARMAZENA);
    assign pronto          = (estado_q == FINAL);
    assign erro            = (estado_q == ERRO);
    assign endereco_linha  = linha_q;
    assign endereco_coluna = coluna_q;
    assign dado_escrita    = dado_q;

    always_comb begin
        case (estado_q)
            INICIAL, PREPARACAO, ESPERA_DADO, ARMAZENA,
            CONTA_COLUNA, CONTA_LINHA, FINAL, ERRO: db_estado = estado_q;
            default:                                db_estado = 4'b1110;
        endcase
    end

endmodule

// File: tb/tb_recepcao_serial_matriz.sv
// Directed bench: 3x3 matrix receiver with short timeout, plus a 1x1 instance.
module tb_recepcao_serial_matriz;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0, pronto_rx = 1'b0, erro_rx = 1'b0;
    logic [7:0] dado_rx = '0;
    logic       escreve, pronto, erro;
    logic [1:0] lin, col;
    logic [7:0] dado_escrita;
    logic [3:0] db_estado;

    logic       iniciar1 = 1'b0, pronto_rx1 = 1'b0, erro_rx1 = 1'b0;
    logic [7:0] dado_rx1 = '0;
    logic       escreve1, pronto1, erro1;
    logic [0:0] lin1, col1;
    logic [7:0] dado_escrita1;
    logic [3:0] db_estado1;

    int checks = 0;
    int failures = 0;
    int n_wr = 0;
    int n_pronto = 0;

    typedef struct {
        logic [7:0] dado;
        logic [1:0] lin;
        logic [1:0] col;
    } vec_t;
    vec_t tbl [9];

    always #5 clock = ~clock;

    recepcao_serial_matriz #(.LINHAS(3), .COLUNAS(3), .DADO_W(8), .TIMEOUT(20)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .pronto_rx(pronto_rx),
        .dado_rx(dado_rx), .erro_rx(erro_rx), .escreve(escreve),
        .endereco_linha(lin), .endereco_coluna(col), .dado_escrita(dado_escrita),
        .pronto(pronto), .erro(erro), .db_estado(db_estado)
    );

    recepcao_serial_matriz #(.LINHAS(1), .COLUNAS(1), .DADO_W(8), .TIMEOUT(20)) dut1 (
        .clock(clock), .reset(reset), .iniciar(iniciar1), .pronto_rx(pronto_rx1),
        .dado_rx(dado_rx1), .erro_rx(erro_rx1), .escreve(escreve1),
        .endereco_linha(lin1), .endereco_coluna(col1), .dado_escrita(dado_escrita1),
        .pronto(pronto1), .erro(erro1), .db_estado(db_estado1)
    );

    always @(negedge clock) begin
        if (escreve) n_wr++;
        if (pronto)  n_pronto++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one byte sampled at the next rising edge; returns at the following falling edge.
    task automatic pulse_byte(input logic [7:0] d, input logic e);
        @(posedge clock); #1;
        pronto_rx = 1'b1; dado_rx = d; erro_rx = e;
        @(posedge clock); #1;
        pronto_rx = 1'b0; erro_rx = 1'b0;
        @(negedge clock);
    endtask

    task automatic start();
        @(posedge clock); #1 iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0;
        @(negedge clock);
        chk("prep_db", db_estado, 4'b0001);
        @(negedge clock);
        chk("espera_db", db_estado, 4'b0010);
        chk("start_lin", lin, 0);
        chk("start_col", col, 0);
    endtask

    task automatic run_matrix(input int err_idx, input int inj_idx);
        for (int i = 0; i < 9; i++) begin
            if (i != 0) begin
                repeat (8) @(negedge clock);
                chk("wait_db", db_estado, 4'b0010);
            end
            pulse_byte(tbl[i].dado, i == err_idx);
            if (i == err_idx) begin
                chk("err_escreve", escreve, 0);
                chk("err_erro", erro, 1);
                chk("err_db", db_estado, 4'b1000);
                return;
            end
            chk("wr_escreve", escreve, 1);
            chk("wr_lin", lin, tbl[i].lin);
            chk("wr_col", col, tbl[i].col);
            chk("wr_dado", dado_escrita, tbl[i].dado);
            chk("wr_db", db_estado, 4'b0011);
            if (i == inj_idx) begin
                pronto_rx = 1'b1; dado_rx = 8'hEE; iniciar = 1'b1;
                @(posedge clock); #1;
                pronto_rx = 1'b0; iniciar = 1'b0;
            end
        end
        @(negedge clock); chk("pronto_e1", pronto, 0);
        @(negedge clock); chk("pronto_e2", pronto, 0);
        @(negedge clock);
        chk("pronto_e3", pronto, 1);
        chk("final_db", db_estado, 4'b0111);
        chk("final_lin", lin, 2);
        chk("final_col", col, 0);
        @(negedge clock);
        chk("after_pronto", pronto, 0);
        chk("after_db", db_estado, 4'b0000);
    endtask

    initial begin
        int wr0, pr0;
        tbl[0] = '{8'h01, 2'd0, 2'd0};
        tbl[1] = '{8'h02, 2'd0, 2'd1};
        tbl[2] = '{8'h03, 2'd0, 2'd2};
        tbl[3] = '{8'h04, 2'd1, 2'd0};
        tbl[4] = '{8'h05, 2'd1, 2'd1};
        tbl[5] = '{8'h06, 2'd1, 2'd2};
        tbl[6] = '{8'h07, 2'd2, 2'd0};
        tbl[7] = '{8'h08, 2'd2, 2'd1};
        tbl[8] = '{8'h09, 2'd2, 2'd2};

        #2;
        chk("rst_outs", {escreve, pronto, erro, lin, col, dado_escrita}, 0);
        chk("rst_db", db_estado, 4'b0000);
        chk("rst_db1", db_estado1, 4'b0000);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_db", db_estado, 4'b0000);

        // Full matrix
        wr0 = n_wr; pr0 = n_pronto;
        start();
        run_matrix(-1, -1);
        chk("full_wr_count", n_wr - wr0, 9);
        chk("full_pronto_count", n_pronto - pr0, 1);

        // Receiver error on byte 4, then recovery
        wr0 = n_wr;
        start();
        run_matrix(3, -1);
        repeat (10) @(negedge clock);
        chk("err_held", erro, 1);
        chk("err_held_db", db_estado, 4'b1000);
        chk("err_wr_count", n_wr - wr0, 3);
        start();
        run_matrix(-1, -1);

        // Timeout: erro 20 cycles after re-entering espera_dado
        start();
        pulse_byte(8'h55, 1'b0);
        chk("to_wr", escreve, 1);
        repeat (21) @(negedge clock);
        chk("to_before", erro, 0);
        chk("to_before_db", db_estado, 4'b0010);
        @(negedge clock);
        chk("to_erro", erro, 1);
        chk("to_db", db_estado, 4'b1000);

        // Byte on the last timeout cycle is stored instead
        start();
        pulse_byte(8'h66, 1'b0);
        chk("late_wr1", escreve, 1);
        repeat (21) @(negedge clock);
        pronto_rx = 1'b1; dado_rx = 8'h77;
        @(posedge clock); #1 pronto_rx = 1'b0;
        @(negedge clock);
        chk("late_escreve", escreve, 1);
        chk("late_erro", erro, 0);
        chk("late_dado", dado_escrita, 8'h77);
        chk("late_col", col, 1);

        // Reset asserted while in armazena
        reset = 1'b0;
        #1;
        chk("midrst_outs", {escreve, pronto, erro, lin, col, dado_escrita}, 0);
        chk("midrst_db", db_estado, 4'b0000);
        @(negedge clock);
        reset = 1'b1;

        // Spurious pronto_rx and iniciar during armazena are ignored
        wr0 = n_wr; pr0 = n_pronto;
        start();
        run_matrix(-1, 1);
        chk("inj_wr_count", n_wr - wr0, 9);
        chk("inj_pronto_count", n_pronto - pr0, 1);

        // 1x1 instance
        @(posedge clock); #1 iniciar1 = 1'b1;
        @(posedge clock); #1 iniciar1 = 1'b0;
        @(negedge clock); chk("m1_prep", db_estado1, 4'b0001);
        @(negedge clock); chk("m1_espera", db_estado1, 4'b0010);
        @(posedge clock); #1 pronto_rx1 = 1'b1; dado_rx1 = 8'hA5;
        @(posedge clock); #1 pronto_rx1 = 1'b0;
        @(negedge clock);
        chk("m1_escreve", escreve1, 1);
        chk("m1_addr", {lin1, col1}, 0);
        chk("m1_dado", dado_escrita1, 8'hA5);
        @(negedge clock); chk("m1_p1", pronto1, 0);
        @(negedge clock); chk("m1_p2", pronto1, 0);
        @(negedge clock);
        chk("m1_pronto", pronto1, 1);
        chk("m1_final_addr", {lin1, col1}, 0);
        @(negedge clock);
        chk("m1_idle", db_estado1, 4'b0000);
        chk("m1_erro", erro1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/recepcao_serial_matriz.md
Name: recepcao_serial_matriz

Overview:
- Receive-side controller for the pixel/facelet matrix link.
- Consumes bytes delivered by the serial receiver as a `pronto_rx` pulse plus `dado_rx`.
- Writes each byte into a LINHAS×COLUNAS store in raster order: column fastest, then line.
- Contains its own line/column counters and inter-byte timeout. Signals `pronto` when the matrix is complete and `erro` on a receiver error or timeout.

Parameters:
- LINHAS, 3, number of matrix lines.
- COLUNAS, 3, number of matrix columns.
- DADO_W, 8, width of received data word.
- TIMEOUT, 50000000, max clock cycles waited in espera_dado before error (≥2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start reception of one matrix; sampled only in inicial/erro.
- pronto_rx  in  1  one-cycle pulse: `dado_rx` valid.
- dado_rx  in  DADO_W  received byte.
- erro_rx  in  1  parity/framing error flag, qualified by `pronto_rx`.
- escreve  out  1  store write enable, one cycle per byte.
- endereco_linha  out  max(1,clog2(LINHAS))  current line index.
- endereco_coluna  out  max(1,clog2(COLUNAS))  current column index.
- dado_escrita  out  DADO_W  latched byte presented with `escreve`.
- pronto  out  1  one-cycle pulse: full matrix stored.
- erro  out  1  held high in erro state.
- db_estado  out  4  debug state code.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = inicial.
  - Line/column counters, timeout counter and `dado_escrita` clear to 0.
  - All outputs 0; `db_estado` = 0000.
  - Applies mid-operation too; partial matrix is abandoned.
- States (Moore outputs), with `db_estado` code:
  - inicial (0000): idle; `iniciar` → preparacao.
  - preparacao (0001): zero line/column counters → espera_dado.
  - espera_dado (0010): timeout counter increments each cycle; it clears on every entry to this state.
    - If `pronto_rx` & `erro_rx` → erro.
    - Else if `pronto_rx` → armazena, and `dado_rx` is latched into `dado_escrita` on that edge.
    - Else if timeout counter == TIMEOUT-1 → erro.
    - `pronto_rx` has priority over timeout on the same cycle.
  - armazena (0011): `escreve`=1 for exactly this cycle; address = current counters; `dado_escrita` stable → conta_coluna_pixel.
  - conta_coluna_pixel (0101): column++.
    - If column was COLUNAS-1: column wraps to 0 → conta_linha_pixel.
    - Else → espera_dado.
  - conta_linha_pixel (0110):
    - If line was LINHAS-1: line stays (no increment) → final.
    - Else line++ → espera_dado.
  - final (0111): `pronto`=1 one cycle → inicial.
  - erro (1000): `erro`=1; `iniciar` → preparacao; otherwise stay.
  - Any illegal encoding: `db_estado`=1110, next state inicial.
- Latency and ordering:
  - First `escreve` occurs 1 cycle after the `pronto_rx` that was sampled in espera_dado.
  - `pronto` occurs 3 cycles after the last byte's `pronto_rx`.
- Ignored inputs:
  - `pronto_rx` outside espera_dado is ignored; that byte is dropped and no error is raised. Upstream rate guarantees ≥4 cycles between bytes.
  - `iniciar` outside inicial/erro is ignored.
  - `erro_rx` without `pronto_rx` is ignored.
- Counters and addresses:
  - Counters are unsigned and never exceed LINHAS-1 / COLUNAS-1.
  - Addresses are combinational from the counters and valid in every state.
  - After final, addresses read line=LINHAS-1, column=0 until the next preparacao.
- Exactly LINHAS×COLUNAS `escreve` pulses per successful matrix.

Test Plan:
- Reset low mid-armazena → all outputs 0 immediately, `db_estado`=0000; after release, `iniciar` starts at address (0,0).
- `iniciar`, then 9 bytes 0x01..0x09 spaced 10 cycles → 9 `escreve` pulses at (0,0),(0,1),(0,2),(1,0)…(2,2) carrying 0x01..0x09; one `pronto` pulse 3 cycles after the 9th `pronto_rx`; return to inicial.
- Byte 4 (0x04) arrives with `erro_rx`=1 → no write for it; `erro`=1, `db_estado`=1000 held. A following `iniciar` → preparacao, addresses (0,0), and a full 9-byte matrix then completes.
- TIMEOUT=20, one byte then silence → `erro` asserts exactly 20 cycles after re-entering espera_dado; `pronto_rx` arriving on cycle 19 instead yields a normal store and no error.
- `pronto_rx` pulse injected during armazena, plus `iniciar` pulsed mid-matrix → the injected byte is not written, the count of `escreve` pulses is unchanged, and the matrix still needs 9 accepted bytes.
- LINHAS=1, COLUNAS=1 → a single byte gives one `escreve` at (0,0), then `pronto`; counters stay 0.
